// File: rtl/shared_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_dff_write_arbiter
// Purpose  : Round-robin arbiter that lets NREQ requesters share write access
//            to one WIDTH-bit register. A grant is issued one cycle after a
//            request is seen in IDLE. The granted requester's data is written
//            on the following edge. At most one write is committed every two
//            cycles.
// Ports    : clk_i    - single clock, rising edge
//            rst_i    - synchronous active-high reset
//            req_i    - per-requester level request (bit i = requester i)
//            wdata_i  - requester i data in bits [i*WIDTH +: WIDTH]
//            clr_i    - synchronous clear of the shared register
//            gnt_o    - registered one-hot grant, one cycle per write
//            q_o      - shared register contents
//            owner_o  - index of the requester whose data is in q_o
//            upd_o    - one-cycle pulse the cycle after q_o takes a write
// Revision : 1.0 - initial release
// ============================================================================
module shared_dff_write_arbiter #(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   wdata_i,
  input  logic                    clr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]        q_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    upd_o
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [WIDTH-1:0]  q_q,     q_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              upd_q,   upd_d;
  logic [PW-1:0]     ptr_q,   ptr_d;
  logic [PW-1:0]     win_q,   win_d;   // requester granted in the current GRANT cycle

  logic [WIDTH-1:0]  slice [NREQ];
  logic              found;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     win_next;
  int                idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = wdata_i[i*WIDTH +: WIDTH];
  end

  // Round-robin search: first set request at or above ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign win_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    upd_d   = 1'b0;
    ptr_d   = ptr_q;
    win_d   = win_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[sel] = 1'b1;
          win_d      = sel;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        // The write is committed regardless of req in this cycle; data is
        // taken from the live wdata at this edge.
        state_d = S_IDLE;
        q_d     = slice[win_q];
        owner_d = win_q;
        ptr_d   = win_next;
        upd_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear beats a pending write, but the grant and pointer advance stand.
    if (clr_i) begin
      q_d     = RESET_VAL;
      owner_d = '0;
      upd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      q_q     <= RESET_VAL;
      owner_q <= '0;
      upd_q   <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      upd_q   <= upd_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign q_o     = q_q;
  assign owner_o = owner_q;
  assign upd_o   = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_dff_write_arbiter
// Purpose  : Directed self-checking bench for shared_dff_write_arbiter
//            (NREQ=4, WIDTH=8, RESET_VAL=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NREQ-1:0]  req_i;
  logic [31:0]      wdata_i;
  logic             clr_i;
  logic [NREQ-1:0]  gnt_o;
  logic [WIDTH-1:0] q_o;
  logic [1:0]       owner_o;
  logic             upd_o;

  int checks = 0;
  int errors = 0;

  shared_dff_write_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .wdata_i (wdata_i),
    .clr_i   (clr_i),
    .gnt_o   (gnt_o),
    .q_o     (q_o),
    .owner_o (owner_o),
    .upd_o   (upd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag, input logic [7:0] exp_q, input logic [1:0] exp_owner);
    check({tag, ".gnt"},   32'(gnt_o),   32'h0);
    check({tag, ".q"},     32'(q_o),     32'(exp_q));
    check({tag, ".owner"}, 32'(owner_o), 32'(exp_owner));
    check({tag, ".upd"},   32'(upd_o),   32'h0);
  endtask

  // Round-robin expectation table: grants 0,1,2,3,0 with slices 11,22,33,44
  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_q    [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [1:0] rr_own  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst_i   = 1'b1;
    clr_i   = 1'b0;
    req_i   = 4'b1011;
    wdata_i = 32'hDEADBEEF;

    // Reset held two cycles with busy inputs
    tick(); check_idle_outs("rst0", 8'h00, 2'd0);
    req_i = 4'b0110; wdata_i = 32'h12345678;
    tick(); check_idle_outs("rst1", 8'h00, 2'd0);
    rst_i = 1'b0;
    req_i = 4'b0000;
    tick(); check_idle_outs("post_rst", 8'h00, 2'd0);

    // Round robin with all requesters active, starting at requester 0
    wdata_i = {8'h44, 8'h33, 8'h22, 8'h11};
    req_i   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr%0d.gnt", i), 32'(gnt_o), 32'(rr_gnt[i]));
      check($sformatf("rr%0d.upd0", i), 32'(upd_o), 32'h0);
      tick();
      check($sformatf("rr%0d.gnt_off", i), 32'(gnt_o), 32'h0);
      check($sformatf("rr%0d.q", i), 32'(q_o), 32'(rr_q[i]));
      check($sformatf("rr%0d.owner", i), 32'(owner_o), 32'(rr_own[i]));
      check($sformatf("rr%0d.upd", i), 32'(upd_o), 32'h1);
    end
    req_i = 4'b0000;
    tick(); check_idle_outs("rr_end", 8'h11, 2'd0);

    // Single requester 2 (ptr=1, requester 1 idle so it is skipped)
    wdata_i = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_i   = 4'b0100;
    tick(); check("single.gnt", 32'(gnt_o), 32'b0100);
    tick();
    check("single.q", 32'(q_o), 32'hA5);
    check("single.owner", 32'(owner_o), 32'd2);
    check("single.upd", 32'(upd_o), 32'h1);
    req_i = 4'b0000;
    tick(); check_idle_outs("single_after", 8'hA5, 2'd2);

    // Wrap and skip: ptr=3, req=0011 -> requester 0, then requester 1
    wdata_i = {8'h00, 8'h00, 8'hB2, 8'hB1};
    req_i   = 4'b0011;
    tick(); check("wrap.gnt0", 32'(gnt_o), 32'b0001);
    tick();
    check("wrap.q0", 32'(q_o), 32'hB1);
    check("wrap.owner0", 32'(owner_o), 32'd0);
    req_i = 4'b0010;
    tick(); check("wrap.gnt1", 32'(gnt_o), 32'b0010);
    tick();
    check("wrap.q1", 32'(q_o), 32'hB2);
    check("wrap.owner1", 32'(owner_o), 32'd1);
    check("wrap.upd1", 32'(upd_o), 32'h1);
    req_i = 4'b0000;
    tick();

    // Clear colliding with a GRANT write of 0x3C from requester 2 (ptr=2)
    wdata_i = {8'h00, 8'h3C, 8'h00, 8'h00};
    req_i   = 4'b0100;
    tick(); check("clrcol.gnt", 32'(gnt_o), 32'b0100);
    clr_i = 1'b1;
    tick();
    check_idle_outs("clrcol", 8'h00, 2'd0);
    clr_i = 1'b0;
    req_i = 4'b0000;
    tick();
    // ptr must now be 3: req 0110 picks requester 1 (ptr=2 would pick 2)
    wdata_i = {8'h00, 8'h00, 8'h77, 8'h00};
    req_i   = 4'b0110;
    tick(); check("clrcol.ptr_adv", 32'(gnt_o), 32'b0010);
    tick();
    check("clrcol.q77", 32'(q_o), 32'h77);
    check("clrcol.owner1", 32'(owner_o), 32'd1);
    req_i = 4'b0000;
    tick();

    // Clear alone in IDLE
    clr_i = 1'b1;
    tick(); check_idle_outs("clr_idle", 8'h00, 2'd0);
    clr_i = 1'b0;
    tick(); check_idle_outs("clr_idle_hold", 8'h00, 2'd0);

    // Reset during a GRANT cycle for requester 3 writing 0x5A (ptr=2)
    wdata_i = {8'h5A, 8'h00, 8'h6B, 8'h00};
    req_i   = 4'b1000;
    tick(); check("rstmid.gnt", 32'(gnt_o), 32'b1000);
    rst_i = 1'b1;
    tick(); check_idle_outs("rstmid", 8'h00, 2'd0);
    rst_i = 1'b0;
    // ptr back at 0: req 1010 picks requester 1 first, then requester 3
    req_i = 4'b1010;
    tick(); check("rstmid.regnt1", 32'(gnt_o), 32'b0010);
    tick();
    check("rstmid.q1", 32'(q_o), 32'h6B);
    check("rstmid.owner1", 32'(owner_o), 32'd1);
    req_i = 4'b1000;
    tick(); check("rstmid.regnt3", 32'(gnt_o), 32'b1000);
    tick();
    check("rstmid.q3", 32'(q_o), 32'h5A);
    check("rstmid.owner3", 32'(owner_o), 32'd3);
    check("rstmid.upd3", 32'(upd_o), 32'h1);
    req_i = 4'b0000;
    tick(); check_idle_outs("final", 8'h5A, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shared_dff_write_arbiter.md
# shared_dff_write_arbiter

Round-robin arbiter that lets NREQ requesters share write access to one WIDTH-bit shared register built from edge-triggered D flip-flops. It sits between the requesters and the shared register and decides which requester's data is written on each grant. It also sequences the grant/write/update handshake and owns the register's synchronous clear. At most one write is committed every two cycles.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width in bits
- RESET_VAL, 0, value loaded into the shared register on reset and on clear
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level, bit i = requester i
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of the shared register
- gnt  output  NREQ  registered one-hot grant, high for exactly one cycle per write
- q  output  WIDTH  shared register contents
- owner  output  clog2(NREQ)  index of the requester whose data is currently in q
- upd  output  1  one-cycle pulse, high the cycle after q takes a granted write

## Operation
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - Reset values: state=IDLE, gnt=0, q=RESET_VAL, owner=0, upd=0, round-robin pointer ptr=0.
- State machine, two states:
  - IDLE: if req != 0, select the winner w = first set req bit searching upward from ptr with wrap (ptr, ptr+1, …, NREQ-1, 0, …). Register gnt = onehot(w), go to GRANT. If req == 0, stay in IDLE with gnt=0.
  - GRANT: unconditionally return to IDLE.
    - At that edge: q <= wdata slice w, owner <= w, ptr <= (w+1) mod NREQ, gnt <= 0, upd <= 1.
- A grant is committed once issued:
  - If req[w] drops during GRANT, the write still occurs, using wdata slice w sampled at the GRANT-cycle edge.
- Requester contract:
  - Hold req and wdata stable from assertion until the edge at which gnt[i] is sampled high.
  - Deassert req at that edge. A req still high in the following IDLE cycle is a new request.
- Only requests seen in IDLE are arbitrated. A req arriving during GRANT waits for the next IDLE.
- clr:
  - When high, q <= RESET_VAL and owner <= 0 at the edge. It has priority over a GRANT write.
  - In a clr+GRANT collision, the grant still completes: gnt pulse and ptr advance occur, but q is cleared, owner=0 and upd stays 0.
  - clr does not change state or ptr otherwise.
- rst has priority over everything. rst asserted during GRANT aborts the write; all outputs take reset values at that edge.
- upd is 0 in every cycle not directly following a committed GRANT write.

## Timing
- Request-to-grant latency: req high in IDLE cycle n -> gnt high in cycle n+1.
- Grant-to-data: q holds the new value in cycle n+2, with upd high in cycle n+2.
- Throughput: at most one write per 2 cycles. Back-to-back requesters are granted in cycles n+1, n+3, n+5, …
- Fairness: with all NREQ requesters continuously requesting (re-asserting after each grant), each is granted once every 2*NREQ cycles.
- gnt is never high in two consecutive cycles. gnt is always one-hot or zero.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset: assert rst 2 cycles with random req/wdata -> gnt=0, q=RESET_VAL, owner=0, upd=0 throughout. First request after release is granted starting from requester 0.
- Single requester: req=0b0100, wdata slice 2=0xA5 at cycle n -> gnt=0b0100 at n+1. q=0xA5, owner=2, upd=1 at n+2. upd=0 at n+3.
- Round-robin: req=0b1111 held (re-asserting) from ptr=0 -> grants 0b0001, 0b0010, 0b0100, 0b1000, 0b0001 in cycles n+1, n+3, n+5, n+7, n+9. q follows each slice.
- Wrap and skip: ptr=3 (after a grant to 2), req=0b0011 -> gnt=0b0001, then ptr=1 -> next gnt=0b0010.
- clr collision: clr high in the GRANT cycle of a write of 0x3C -> q=RESET_VAL, owner=0, upd=0, and ptr still advanced. clr alone in IDLE with q=0x77 -> q=RESET_VAL next cycle, no gnt.
- Reset mid-operation: rst high during a GRANT cycle for wdata 0x5A -> q=RESET_VAL, gnt=0, upd=0 after the edge. Requester re-requests and is granted normally.
